// File: rtl/sakebi_rx_frame_ctrl.sv
// Receive frame controller: delimits the rmii byte stream by idle timeout, filters on
// destination MAC, enforces length limits and re-emits frames as AXI-Stream with statistics.
module sakebi_rx_frame_ctrl #(
    parameter int IDLE_TIMEOUT = 16,
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518
) (
    input  logic        i_axis_ACLK,
    input  logic        i_axis_ARESETn,
    input  logic        i_rx_TVALID,
    input  logic [7:0]  i_rx_TDATA,
    input  logic        i_cfg_enable,
    input  logic        i_cfg_promisc,
    input  logic [47:0] i_cfg_mac,
    output logic        o_axis_TVALID,
    output logic [7:0]  o_axis_TDATA,
    output logic        o_axis_TLAST,
    output logic        o_axis_TUSER,
    input  logic        i_stat_clear,
    output logic [15:0] o_stat_good,
    output logic [15:0] o_stat_filtered,
    output logic [15:0] o_stat_error,
    output logic        o_busy
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PASS, S_DISCARD, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  fifo_data [8];
    logic [7:0]  fifo_last, fifo_err;
    logic [2:0]  rd_ptr, wr_ptr;
    logic [3:0]  occ, occ_nx;
    logic [10:0] byte_cnt, cnt_inc;
    logic [7:0]  idle_cnt, idle_next;
    logic        cfg_promisc_q;
    logic [47:0] cfg_mac_q, hdr_bytes;
    logic        in_frame, eof, hdr_last, mac_match, oversize, pop;
    logic        push, push_ok, push_last, push_err, mark_last, mark_err, flush;
    logic        inc_good, inc_filt, inc_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_frame  = (state_q == S_HDR) || (state_q == S_PASS) || (state_q == S_DISCARD);
    assign idle_next = idle_cnt + 8'd1;
    assign eof       = in_frame && !i_rx_TVALID && (idle_next == 8'(IDLE_TIMEOUT));
    assign cnt_inc   = byte_cnt + 11'd1;
    assign hdr_last  = (state_q == S_HDR) && i_rx_TVALID && (byte_cnt == 11'd5);
    // Header bytes 0..4 are still in the FIFO: nothing pops before the filter decision.
    assign hdr_bytes = {fifo_data[rd_ptr], fifo_data[rd_ptr + 3'd1], fifo_data[rd_ptr + 3'd2],
                        fifo_data[rd_ptr + 3'd3], fifo_data[rd_ptr + 3'd4], i_rx_TDATA};
    assign mac_match = cfg_promisc_q || (hdr_bytes == cfg_mac_q) || (hdr_bytes == 48'hFFFF_FFFF_FFFF);
    assign oversize  = (state_q == S_PASS) && i_rx_TVALID && (cnt_inc == 11'(MAX_LEN));
    assign pop       = ((state_q == S_PASS) || (state_q == S_DISCARD) || (state_q == S_DRAIN)) &&
                       ((occ >= 4'd2) || ((occ == 4'd1) && fifo_last[rd_ptr]));
    assign push_ok   = push && ((occ != 4'd8) || pop);
    assign occ_nx    = flush ? 4'd0 : occ + {3'd0, push_ok} - {3'd0, pop};
    assign o_busy    = (state_q != S_IDLE);

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) state_q <= S_IDLE;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (i_rx_TVALID) state_d = i_cfg_enable ? S_HDR : S_DISCARD;
            S_HDR:     if (eof) state_d = S_IDLE;
                       else if (hdr_last) state_d = mac_match ? S_PASS : S_DISCARD;
            S_PASS:    if (oversize) state_d = S_DISCARD;
                       else if (eof) state_d = S_DRAIN;
            S_DISCARD: if (eof) state_d = (occ_nx != 4'd0) ? S_DRAIN : S_IDLE;
            S_DRAIN:   if (occ_nx == 4'd0) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push = 1'b0; push_last = 1'b0; push_err = 1'b0;
        mark_last = 1'b0; mark_err = 1'b0; flush = 1'b0;
        inc_good = 1'b0; inc_filt = 1'b0; inc_err = 1'b0;
        case (state_q)
            S_IDLE: push = i_rx_TVALID && i_cfg_enable;
            S_HDR: begin
                if (eof) begin
                    flush = 1'b1; inc_err = 1'b1;
                end else if (hdr_last && !mac_match) begin
                    flush = 1'b1; inc_filt = 1'b1;
                end else begin
                    push = i_rx_TVALID;
                end
            end
            S_PASS: begin
                if (i_rx_TVALID) begin
                    push = 1'b1; push_last = oversize; push_err = oversize; inc_err = oversize;
                end else if (eof) begin
                    mark_last = 1'b1;
                    mark_err  = (byte_cnt < 11'(MIN_LEN));
                    inc_err   = mark_err;
                    inc_good  = !mark_err;
                end
            end
            S_DRAIN: inc_err = i_rx_TVALID;
            default: ;
        endcase
        // A push into a full FIFO is dropped and counted as an overrun.
        if (push && !push_ok) inc_err = 1'b1;
    end

    always_ff @(posedge i_axis_ACLK) begin
        if (push_ok && !flush) begin
            fifo_data[wr_ptr] <= i_rx_TDATA;
            fifo_last[wr_ptr] <= push_last;
            fifo_err[wr_ptr]  <= push_err;
        end
        if (mark_last) begin
            fifo_last[wr_ptr - 3'd1] <= 1'b1;
            fifo_err[wr_ptr - 3'd1]  <= mark_err;
        end
        if ((state_q == S_IDLE) && i_rx_TVALID) begin
            cfg_mac_q     <= i_cfg_mac;
            cfg_promisc_q <= i_cfg_promisc;
        end
    end

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            rd_ptr <= '0; wr_ptr <= '0; occ <= '0;
            byte_cnt <= '0; idle_cnt <= '0;
            o_axis_TVALID <= 1'b0; o_axis_TDATA <= '0; o_axis_TLAST <= 1'b0; o_axis_TUSER <= 1'b0;
        end else begin
            occ <= occ_nx;
            if (flush) begin
                rd_ptr <= '0; wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 3'd1;
                if (pop)     rd_ptr <= rd_ptr + 3'd1;
            end
            if ((state_q == S_IDLE) && i_rx_TVALID)
                byte_cnt <= 11'd1;
            else if (((state_q == S_HDR) || (state_q == S_PASS)) && i_rx_TVALID)
                byte_cnt <= cnt_inc;
            idle_cnt      <= (in_frame && !i_rx_TVALID && !eof) ? idle_next : 8'd0;
            o_axis_TVALID <= pop;
            o_axis_TDATA  <= pop ? fifo_data[rd_ptr] : 8'd0;
            o_axis_TLAST  <= pop && fifo_last[rd_ptr];
            o_axis_TUSER  <= pop && fifo_err[rd_ptr];
        end
    end

    // Statistics: clear has priority over any increment in the same cycle.
    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            o_stat_good <= '0; o_stat_filtered <= '0; o_stat_error <= '0;
        end else if (i_stat_clear) begin
            o_stat_good <= '0; o_stat_filtered <= '0; o_stat_error <= '0;
        end else begin
            if (inc_good) o_stat_good     <= sat_inc(o_stat_good);
            if (inc_filt) o_stat_filtered <= sat_inc(o_stat_filtered);
            if (inc_err)  o_stat_error    <= sat_inc(o_stat_error);
        end
    end

endmodule

// File: tb/tb_sakebi_rx_frame_ctrl.sv
// Bench for sakebi_rx_frame_ctrl: table vectors, timing corner sequences and random frames
// checked against a frame-level reference model.
module tb_sakebi_rx_frame_ctrl;

    localparam int IDLE_TIMEOUT = 16;
    localparam int MIN_LEN      = 64;
    localparam int MAX_LEN      = 1518;
    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        cfg_enable = 1'b1;
    logic        cfg_promisc = 1'b0;
    logic [47:0] cfg_mac = MAC;
    logic        stat_clear = 1'b0;
    logic        out_valid, out_last, out_user, busy;
    logic [7:0]  out_data;
    logic [15:0] stat_good, stat_filt, stat_err;

    sakebi_rx_frame_ctrl #(.IDLE_TIMEOUT(IDLE_TIMEOUT), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
        .i_rx_TVALID(rx_valid), .i_rx_TDATA(rx_data),
        .i_cfg_enable(cfg_enable), .i_cfg_promisc(cfg_promisc), .i_cfg_mac(cfg_mac),
        .o_axis_TVALID(out_valid), .o_axis_TDATA(out_data), .o_axis_TLAST(out_last), .o_axis_TUSER(out_user),
        .i_stat_clear(stat_clear), .o_stat_good(stat_good), .o_stat_filtered(stat_filt),
        .o_stat_error(stat_err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [47:0] dest;
        bit          en;
        bit          pr;
        int          gap;
        int          exp_n;
        bit          exp_user;
        int          exp_good;
        int          exp_filt;
        int          exp_err;
    } vec_t;

    vec_t        vecs [12];
    logic [7:0]  frm [$];
    logic [9:0]  got_q [$];
    int          got_cyc [$];
    logic [9:0]  exp_q [$];
    int          d_good, d_filt, d_err;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back({out_data, out_last, out_user});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic clear_stats();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    // mode 0: random payload, mode 1: payload byte i = i
    task automatic build_frame(input int len, input logic [47:0] dest, input int mode);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6)          frm.push_back(dest[47 - 8*i -: 8]);
            else if (mode == 1) frm.push_back(8'(i));
            else                frm.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // gap < 0 means a random gap of 0..3 idle cycles between bytes
    task automatic send_frame(input int gap);
        for (int i = 0; i < frm.size(); i++) begin
            drive_byte(frm[i]);
            if (i < frm.size() - 1) idle((gap < 0) ? int'($urandom_range(0, 3)) : gap);
        end
    endtask

    // Frame-level expectation derived from the acceptance rules, independent of timing.
    task automatic model_frame(input bit en, input bit pr, input logic [47:0] mac);
        int          len, n;
        bit          err;
        logic [47:0] dest;
        exp_q.delete();
        d_good = 0; d_filt = 0; d_err = 0;
        len = frm.size();
        if (!en) return;
        if (len < 6) begin
            d_err = 1;
            return;
        end
        dest = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        if (!(pr || dest == mac || dest == BCAST)) begin
            d_filt = 1;
            return;
        end
        n   = (len >= MAX_LEN) ? MAX_LEN : len;
        err = (len >= MAX_LEN) || (len < MIN_LEN);
        for (int i = 0; i < n; i++)
            exp_q.push_back({frm[i], (i == n - 1), (i == n - 1) && err});
        if (err) d_err = 1;
        else     d_good = 1;
    endtask

    task automatic check_content(input string name);
        int errs = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) errs++;
        check({name, " content"}, errs, 0);
        check({name, " nbytes vs model"}, got_q.size(), exp_q.size());
    endtask

    initial begin
        int k, t, len, sel, c_good, c_filt, c_err;
        logic [47:0] dest;
        bit en, pr;

        vecs[0]  = '{64,   MAC,   1, 0, 3, 64,   0, 1, 0, 0};
        vecs[1]  = '{64,   OTHER, 1, 0, 1, 0,    0, 0, 1, 0};
        vecs[2]  = '{64,   OTHER, 1, 1, 1, 64,   0, 1, 0, 0};
        vecs[3]  = '{64,   BCAST, 1, 0, 1, 64,   0, 1, 0, 0};
        vecs[4]  = '{40,   MAC,   1, 0, 2, 40,   1, 0, 0, 1};
        vecs[5]  = '{4,    MAC,   1, 0, 2, 0,    0, 0, 0, 1};
        vecs[6]  = '{64,   MAC,   0, 0, 1, 0,    0, 0, 0, 0};
        vecs[7]  = '{1600, MAC,   1, 0, 0, 1518, 1, 0, 0, 1};
        vecs[8]  = '{6,    MAC,   1, 0, 0, 6,    1, 0, 0, 1};
        vecs[9]  = '{65,   MAC,   1, 0, 0, 65,   0, 1, 0, 0};
        vecs[10] = '{1518, MAC,   1, 0, 0, 1518, 1, 0, 0, 1};
        vecs[11] = '{1517, MAC,   1, 0, 0, 1517, 0, 1, 0, 0};

        // Reset state
        repeat (3) tick();
        check("reset tvalid", out_valid, 0);
        check("reset tlast", out_last, 0);
        check("reset busy", busy, 0);
        check("reset good", stat_good, 0);
        check("reset error", stat_err, 0);
        rst_n = 1'b1;
        idle(3);

        // 64-byte frame, one byte every 4 cycles: TLAST timing after the idle timeout
        build_frame(64, MAC, 0);
        model_frame(1'b1, 1'b0, MAC);
        got_q.delete();
        send_frame(3);
        k = 99;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_last && k == 99) begin
                k = i;
                check("t1 busy at tlast", busy, 0);
            end
        end
        check("t1 tlast edge after last byte", k - 1, IDLE_TIMEOUT + 1);
        idle(4);
        check_content("t1");
        check("t1 good", stat_good, 1);

        // Table-driven frames
        for (int v = 0; v < 12; v++) begin
            clear_stats();
            cfg_enable  = vecs[v].en;
            cfg_promisc = vecs[v].pr;
            build_frame(vecs[v].len, vecs[v].dest, 0);
            model_frame(vecs[v].en, vecs[v].pr, MAC);
            got_q.delete();
            send_frame(vecs[v].gap);
            idle(30);
            check($sformatf("v%0d nbytes", v), got_q.size(), vecs[v].exp_n);
            if (got_q.size() > 0) begin
                check($sformatf("v%0d tlast", v), got_q[got_q.size() - 1][1], 1);
                check($sformatf("v%0d tuser", v), got_q[got_q.size() - 1][0], vecs[v].exp_user);
            end
            check_content($sformatf("v%0d", v));
            check($sformatf("v%0d good", v), stat_good, vecs[v].exp_good);
            check($sformatf("v%0d filtered", v), stat_filt, vecs[v].exp_filt);
            check($sformatf("v%0d error", v), stat_err, vecs[v].exp_err);
            check($sformatf("v%0d busy", v), busy, 0);
        end
        cfg_enable = 1'b1;
        cfg_promisc = 1'b0;

        // Back-to-back bytes: output contiguous until the held final byte
        build_frame(64, MAC, 0);
        got_q.delete();
        got_cyc.delete();
        send_frame(0);
        idle(30);
        check("t5 nbytes", got_q.size(), 64);
        if (got_q.size() == 64) check("t5 contiguous span", got_cyc[62] - got_cyc[0], 62);

        // Counter saturation and clear priority over a same-cycle increment
        force dut.o_stat_good = 16'hFFFE;
        #1;
        release dut.o_stat_good;
        send_frame(0);
        idle(30);
        check("sat reach", stat_good, 16'hFFFF);
        send_frame(0);
        idle(30);
        check("sat hold", stat_good, 16'hFFFF);
        send_frame(0);
        for (int j = 1; j <= 25; j++) begin
            stat_clear = (j >= 10 && j <= 20);
            tick();
        end
        stat_clear = 1'b0;
        check("clear beats increment", stat_good, 0);
        idle(10);

        // Reset in the middle of a frame
        clear_stats();
        build_frame(64, MAC, 1);
        for (int i = 0; i < 30; i++) drive_byte(frm[i]);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst tvalid", out_valid, 0);
        check("rst tlast", out_last, 0);
        check("rst busy", busy, 0);
        got_q.delete();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        drive_byte(frm[30]);
        check("rst new frame busy", busy, 1);
        for (int i = 31; i < 64; i++) drive_byte(frm[i]);
        idle(30);
        check("rst no output", got_q.size(), 0);
        check("rst filtered", stat_filt, 1);
        check("rst good", stat_good, 0);

        // Random frames against the reference model
        clear_stats();
        c_good = 0; c_filt = 0; c_err = 0;
        for (int f = 0; f < 16; f++) begin
            t = $urandom_range(0, 9);
            if (t == 0)      len = $urandom_range(1510, 1600);
            else if (t == 1) len = $urandom_range(1, 5);
            else             len = $urandom_range(6, 120);
            sel = $urandom_range(0, 2);
            if (sel == 0)      dest = MAC;
            else if (sel == 1) dest = BCAST;
            else               dest = {8'h0A, 8'($urandom_range(0, 255)), 32'($urandom)};
            en = ($urandom_range(0, 7) != 0);
            pr = ($urandom_range(0, 3) == 0);
            cfg_enable  = en;
            cfg_promisc = pr;
            build_frame(len, dest, 0);
            model_frame(en, pr, MAC);
            c_good += d_good; c_filt += d_filt; c_err += d_err;
            got_q.delete();
            send_frame(-1);
            idle(30);
            check_content($sformatf("r%0d len%0d", f, len));
            check($sformatf("r%0d good", f), stat_good, c_good);
            check($sformatf("r%0d filtered", f), stat_filt, c_filt);
            check($sformatf("r%0d error", f), stat_err, c_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
